// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with runtime ratio changes at period boundaries
// and glitch-free start/stop.
module clk_div_prog #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_ratio_vld,
    output logic             div_ratio_rdy,
    output logic             divclk,
    output logic             divclk_rise,
    output logic             divclk_active
);

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   cur_ratio;
    logic [DIV_W-1:0]   pend_ratio;
    logic               pend;

    logic [DIV_W-1:0]   cnt_nxt;
    logic [DIV_W-1:0]   ratio_nxt;
    logic [DIV_W-1:0]   pend_ratio_nxt;
    logic               pend_nxt;
    logic               divclk_nxt;
    logic               rise_nxt;
    logic               active_nxt;
    logic               rdy_nxt;

    logic               boundary;
    logic               hs;
    logic [DIV_W-1:0]   ld_val;
    logic [DIV_W-1:0]   high_len;

    assign boundary = (state != ST_STOP) && (cnt == cur_ratio - DIV_W'(1));
    assign hs       = div_ratio_vld && div_ratio_rdy;
    assign ld_val   = (div_ratio < DIV_W'(2)) ? DIV_W'(2) : div_ratio;
    assign high_len = ratio_nxt - (ratio_nxt >> 1);

    // State register
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: stopping only completes on a period boundary
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP:     if (div_en) state_nxt = ST_RUN;
            ST_RUN:      if (!div_en) state_nxt = ST_STOPPING;
            ST_STOPPING: begin
                if (div_en) begin
                    state_nxt = ST_RUN;
                end else if (boundary) begin
                    state_nxt = ST_STOP;
                end
            end
            default:     state_nxt = ST_STOP;
        endcase
    end

    // Counter, ratio handshake and next output values
    always_comb begin
        cnt_nxt        = cnt;
        ratio_nxt      = cur_ratio;
        pend_nxt       = pend;
        pend_ratio_nxt = pend_ratio;

        if (state_nxt == ST_STOP || state == ST_STOP || boundary) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + DIV_W'(1);
        end

        if (boundary && pend) begin
            ratio_nxt = pend_ratio;
            pend_nxt  = 1'b0;
        end

        // Loads made while stopped (or on the stop edge) have no later boundary to wait for
        if (hs) begin
            if (state == ST_STOP || state_nxt == ST_STOP) begin
                ratio_nxt = ld_val;
            end else begin
                pend_nxt       = 1'b1;
                pend_ratio_nxt = ld_val;
            end
        end

        active_nxt = (state_nxt != ST_STOP);
        divclk_nxt = active_nxt && (cnt_nxt < high_len);
        rise_nxt   = active_nxt && (cnt_nxt == '0);
        rdy_nxt    = !pend_nxt;
    end

    // Datapath and output registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            cnt           <= '0;
            cur_ratio     <= DIV_W'(DEFAULT_DIV);
            pend          <= 1'b0;
            pend_ratio    <= '0;
            divclk        <= 1'b0;
            divclk_rise   <= 1'b0;
            divclk_active <= 1'b0;
            div_ratio_rdy <= 1'b1;
        end else begin
            cnt           <= cnt_nxt;
            cur_ratio     <= ratio_nxt;
            pend          <= pend_nxt;
            pend_ratio    <= pend_ratio_nxt;
            divclk        <= divclk_nxt;
            divclk_rise   <= rise_nxt;
            divclk_active <= active_nxt;
            div_ratio_rdy <= rdy_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed vector bench for clk_div_prog (DIV_W=8, DEFAULT_DIV=4).
module tb_clk_div_prog;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       div_en = 1'b0;
    logic [7:0] div_ratio = '0;
    logic       div_ratio_vld = 1'b0;
    logic       div_ratio_rdy;
    logic       divclk;
    logic       divclk_rise;
    logic       divclk_active;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
        .refclk        (refclk),
        .rst           (rst),
        .div_en        (div_en),
        .div_ratio     (div_ratio),
        .div_ratio_vld (div_ratio_vld),
        .div_ratio_rdy (div_ratio_rdy),
        .divclk        (divclk),
        .divclk_rise   (divclk_rise),
        .divclk_active (divclk_active)
    );

    always #5 refclk = ~refclk;

    // exp = {divclk, divclk_rise, divclk_active, div_ratio_rdy} right after the edge
    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] ratio;
        logic       vld;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic [7:0] ra,
                                input logic v, input logic [3:0] x);
        vec_t t;
        t.rst = r; t.en = e; t.ratio = ra; t.vld = v; t.exp = x;
        vecs.push_back(t);
    endfunction

    function automatic void en_seq(input logic e, input logic [3:0] x);
        add(1'b0, e, 8'd0, 1'b0, x);
    endfunction

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int hi;
        int lo;
        int k;
        logic [3:0] got;

        // reset, default ratio 4
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 8'd0, 1'b0, 4'b0001);
        en_seq(1, 4'b1111); en_seq(1, 4'b1011); en_seq(1, 4'b0011); en_seq(1, 4'b0011);
        en_seq(1, 4'b1111); en_seq(1, 4'b1011); en_seq(1, 4'b0011); en_seq(1, 4'b0011);
        // disable at cnt=0: period completes, then stop
        en_seq(1, 4'b1111); en_seq(0, 4'b1011); en_seq(0, 4'b0011); en_seq(0, 4'b0011);
        en_seq(0, 4'b0001); en_seq(0, 4'b0001);
        // re-enable during STOPPING: no gap
        en_seq(1, 4'b1111); en_seq(0, 4'b1011); en_seq(1, 4'b0011); en_seq(1, 4'b0011);
        en_seq(1, 4'b1111); en_seq(1, 4'b1011); en_seq(1, 4'b0011); en_seq(1, 4'b0011);
        // disable on a boundary edge: one whole extra period
        en_seq(0, 4'b1111); en_seq(0, 4'b1011); en_seq(0, 4'b0011); en_seq(0, 4'b0011);
        en_seq(0, 4'b0001);
        // load 5 while stopped, rdy stays high
        add(1'b0, 1'b0, 8'd5, 1'b1, 4'b0001);
        en_seq(1, 4'b1111); en_seq(1, 4'b1011); en_seq(1, 4'b1011); en_seq(1, 4'b0011);
        en_seq(1, 4'b0011); en_seq(1, 4'b1111); en_seq(1, 4'b1011); en_seq(1, 4'b1011);
        en_seq(1, 4'b0011); en_seq(1, 4'b0011);
        // load 4 on a boundary edge: applies at the following boundary
        add(1'b0, 1'b1, 8'd4, 1'b1, 4'b1110);
        en_seq(1, 4'b1010); en_seq(1, 4'b1010); en_seq(1, 4'b0010); en_seq(1, 4'b0010);
        en_seq(1, 4'b1111); en_seq(1, 4'b1011);
        // load 6 at cnt=1; vld while rdy=0 is ignored
        add(1'b0, 1'b1, 8'd6, 1'b1, 4'b0010);
        add(1'b0, 1'b1, 8'd9, 1'b1, 4'b0010);
        en_seq(1, 4'b1111); en_seq(1, 4'b1011); en_seq(1, 4'b1011); en_seq(1, 4'b0011);
        en_seq(1, 4'b0011); en_seq(1, 4'b0011); en_seq(1, 4'b1111);
        // pending load 3 then reset in high phase: load dropped, back to ratio 4
        add(1'b0, 1'b1, 8'd3, 1'b1, 4'b1010);
        add(1'b1, 1'b1, 8'd0, 1'b0, 4'b0001);
        en_seq(0, 4'b0001);
        en_seq(1, 4'b1111); en_seq(1, 4'b1011); en_seq(1, 4'b0011); en_seq(1, 4'b0011);
        en_seq(1, 4'b1111);
        en_seq(0, 4'b1011); en_seq(0, 4'b0011); en_seq(0, 4'b0011); en_seq(0, 4'b0001);
        // ratio 0 clamps to 2
        add(1'b0, 1'b0, 8'd0, 1'b1, 4'b0001);
        en_seq(1, 4'b1111); en_seq(1, 4'b0011); en_seq(1, 4'b1111); en_seq(1, 4'b0011);
        // ratio 1 clamps to 2, loaded while running
        add(1'b0, 1'b1, 8'd1, 1'b1, 4'b1110);
        en_seq(1, 4'b0010); en_seq(1, 4'b1111); en_seq(1, 4'b0011); en_seq(1, 4'b1111);
        // pending load reaching STOP is applied on the STOP-entry edge
        add(1'b0, 1'b0, 8'd3, 1'b1, 4'b0010);
        en_seq(0, 4'b0001);
        en_seq(1, 4'b1111); en_seq(1, 4'b1011); en_seq(1, 4'b0011); en_seq(1, 4'b1111);

        foreach (vecs[i]) begin
            rst           = vecs[i].rst;
            div_en        = vecs[i].en;
            div_ratio     = vecs[i].ratio;
            div_ratio_vld = vecs[i].vld;
            step();
            got = {divclk, divclk_rise, divclk_active, div_ratio_rdy};
            n_tests++;
            if (got !== vecs[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d {divclk,rise,active,rdy}: got %b expected %b",
                         i, got, vecs[i].exp);
            end
        end

        // stop with bounded wait, then check the maximum ratio 255 phase split
        rst = 1'b0; div_en = 1'b0; div_ratio_vld = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (divclk_active && k < 10);
        check("stop_reached_active", int'(divclk_active), 0);
        check("stop_divclk_low", int'(divclk), 0);

        div_ratio = 8'd255; div_ratio_vld = 1'b1;
        step();
        div_ratio_vld = 1'b0;
        check("stopped_load_rdy", int'(div_ratio_rdy), 1);
        div_en = 1'b1;
        step();
        check("r255_start_rise", int'(divclk_rise), 1);
        hi = 0; lo = 0; k = 0;
        while (divclk && k < 300) begin
            hi++; step(); k++;
        end
        while (!divclk && k < 600) begin
            lo++; step(); k++;
        end
        check("r255_high_len", hi, 128);
        check("r255_low_len", lo, 127);
        check("r255_wrap_rise", int'(divclk_rise), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
